// File: rtl/capture_pkg.sv
// Shared types and constants for the acquisition trigger path.
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2,
        TRIGD = 2'd3
    } trig_state_e;

    localparam int          PRE_W   = 9;
    localparam int          TO_W    = 12;
    localparam logic [11:0] AUTO_TO = 12'd4095;

endpackage

// File: rtl/trig_edge_det.sv
// Threshold-crossing detector: remembers the previous decimated sample and
// flags a rising or falling crossing of the latched level on the current one.
module trig_edge_det (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       smpl_vld,
    input  logic [7:0] ch_data,
    input  logic [7:0] lvl,
    input  logic       rising,
    output logic       edge_hit
);

    logic [7:0] prev_q, prev_d;
    logic       prev_valid_q, prev_valid_d;
    logic       cur_above, prev_above;

    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        if (clr) begin
            prev_valid_d = 1'b0;
        end else if (smpl_vld) begin
            prev_d       = ch_data;
            prev_valid_d = 1'b1;
        end
    end

    // With lvl == 0 every sample is "above", so neither crossing can occur.
    always_comb begin
        cur_above  = (ch_data >= lvl);
        prev_above = (prev_q >= lvl);
        if (rising) edge_hit = smpl_vld && prev_valid_q && !prev_above && cur_above;
        else        edge_hit = smpl_vld && prev_valid_q && prev_above && !cur_above;
    end

    // NOTE: state updates use non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

endmodule

// File: rtl/trigger_logic.sv
// Acquisition trigger FSM: pre-trigger fill, armed edge search with optional
// autoroll timeout, and hold in TRIGD until the capture side finishes.
module trigger_logic
    import capture_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       smpl_en,
    input  logic [7:0] ch_data,
    input  logic [7:0] trig_lvl,
    input  logic       trig_edge,
    input  logic [8:0] trig_pos,
    input  logic       autoroll,
    input  logic       start,
    input  logic       stop,
    input  logic       capture_done,
    output logic       armed,
    output logic       trigger,
    output logic       triggered,
    output logic       forced,
    output logic       busy
);

    trig_state_e      state_q, state_d;
    logic [7:0]       lvl_q, lvl_d;
    logic             rising_q, rising_d;
    logic [PRE_W-1:0] pos_q, pos_d;
    logic             auto_q, auto_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             armed_q, armed_d;
    logic             trigger_q, trigger_d;
    logic             triggered_q, triggered_d;
    logic             forced_q, forced_d;
    logic             busy_q, busy_d;

    logic edge_clr, edge_smpl, edge_hit;

    assign edge_clr  = (state_q == IDLE) && start && !stop;
    assign edge_smpl = smpl_en && ((state_q == FILL) || (state_q == ARMED));

    trig_edge_det u_edge_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (edge_clr),
        .smpl_vld (edge_smpl),
        .ch_data  (ch_data),
        .lvl      (lvl_q),
        .rising   (rising_q),
        .edge_hit (edge_hit)
    );

    always_comb begin
        state_d   = state_q;
        lvl_d     = lvl_q;
        rising_d  = rising_q;
        pos_d     = pos_q;
        auto_d    = auto_q;
        pre_cnt_d = pre_cnt_q;
        to_cnt_d  = to_cnt_q;
        forced_d  = forced_q;
        trigger_d = 1'b0;

        if (stop) begin
            state_d  = IDLE;
            forced_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    lvl_d     = trig_lvl;
                    rising_d  = trig_edge;
                    pos_d     = trig_pos;
                    auto_d    = autoroll;
                    pre_cnt_d = '0;
                    state_d   = FILL;
                end
                FILL: begin
                    if (pos_q == '0) begin
                        state_d  = ARMED;
                        to_cnt_d = '0;
                    end else if (smpl_en) begin
                        pre_cnt_d = pre_cnt_q + 9'd1;
                        if (pre_cnt_q + 9'd1 == pos_q) begin
                            state_d  = ARMED;
                            to_cnt_d = '0;
                        end
                    end
                end
                ARMED: begin
                    // A real edge outranks a timeout landing on the same sample.
                    if (edge_hit) begin
                        state_d   = TRIGD;
                        trigger_d = 1'b1;
                        forced_d  = 1'b0;
                    end else if (auto_q && smpl_en) begin
                        if (to_cnt_q == AUTO_TO) begin
                            state_d   = TRIGD;
                            trigger_d = 1'b1;
                            forced_d  = 1'b1;
                        end else begin
                            to_cnt_d = to_cnt_q + 12'd1;
                        end
                    end
                end
                TRIGD: if (capture_done) begin
                    state_d  = IDLE;
                    forced_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end

        armed_d     = (state_d == ARMED);
        triggered_d = (state_d == TRIGD);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lvl_q       <= '0;
            rising_q    <= 1'b0;
            pos_q       <= '0;
            auto_q      <= 1'b0;
            pre_cnt_q   <= '0;
            to_cnt_q    <= '0;
            armed_q     <= 1'b0;
            trigger_q   <= 1'b0;
            triggered_q <= 1'b0;
            forced_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lvl_q       <= lvl_d;
            rising_q    <= rising_d;
            pos_q       <= pos_d;
            auto_q      <= auto_d;
            pre_cnt_q   <= pre_cnt_d;
            to_cnt_q    <= to_cnt_d;
            armed_q     <= armed_d;
            trigger_q   <= trigger_d;
            triggered_q <= triggered_d;
            forced_q    <= forced_d;
            busy_q      <= busy_d;
        end
    end

    assign armed     = armed_q;
    assign trigger   = trigger_q;
    assign triggered = triggered_q;
    assign forced    = forced_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_trigger_logic.sv
// Directed bench for trigger_logic; expected trigger events go into a queue
// and a monitor checks each trigger pulse against the head of that queue.
module tb_trigger_logic;

    logic       clk;
    logic       rst_n;
    logic       smpl_en;
    logic [7:0] ch_data;
    logic [7:0] trig_lvl;
    logic       trig_edge;
    logic [8:0] trig_pos;
    logic       autoroll;
    logic       start;
    logic       stop;
    logic       capture_done;
    logic       armed, trigger, triggered, forced, busy;

    trigger_logic dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .smpl_en      (smpl_en),
        .ch_data      (ch_data),
        .trig_lvl     (trig_lvl),
        .trig_edge    (trig_edge),
        .trig_pos     (trig_pos),
        .autoroll     (autoroll),
        .start        (start),
        .stop         (stop),
        .capture_done (capture_done),
        .armed        (armed),
        .trigger      (trigger),
        .triggered    (triggered),
        .forced       (forced),
        .busy         (busy)
    );

    typedef struct {
        int cyc;
        bit forced;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Every trigger pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && trigger === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected trigger", 32'(trigger), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("trigger cycle", 32'(cyc), 32'(e.cyc));
                check("forced at trigger", 32'(forced), 32'(e.forced));
                check("triggered at trigger", 32'(triggered), 32'd1);
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit exp_trig, input bit exp_forced);
        ch_data = d;
        smpl_en = 1'b1;
        if (exp_trig) exp_q.push_back('{cyc: cyc + 1, forced: exp_forced});
        @(negedge clk);
        smpl_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_done();
        capture_done = 1'b1;
        @(negedge clk);
        capture_done = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic config_trig(input logic [7:0] lvl, input logic rise,
                               input logic [8:0] pos, input logic ar);
        trig_lvl  = lvl;
        trig_edge = rise;
        trig_pos  = pos;
        autoroll  = ar;
    endtask

    task automatic check_drained(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        smpl_en      = 1'b0;
        ch_data      = '0;
        start        = 1'b0;
        stop         = 1'b0;
        capture_done = 1'b0;
        config_trig(8'h00, 1'b0, 9'd0, 1'b0);
        checks = 0;
        errors = 0;

        repeat (2) @(negedge clk);
        check("reset armed", 32'(armed), 32'd0);
        check("reset trigger", 32'(trigger), 32'd0);
        check("reset triggered", 32'(triggered), 32'd0);
        check("reset forced", 32'(forced), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Rising trigger after a four-sample pre-fill.
        config_trig(8'h80, 1'b1, 9'd4, 1'b0);
        pulse_start();
        check("fill busy", 32'(busy), 32'd1);
        check("fill not armed", 32'(armed), 32'd0);
        send(8'h10, 0, 0);
        send(8'h20, 0, 0);
        send(8'h30, 0, 0);
        check("armed before 4th", 32'(armed), 32'd0);
        send(8'h40, 0, 0);
        check("armed after 4th", 32'(armed), 32'd1);
        send(8'h70, 0, 0);
        send(8'h90, 1, 0);
        check("rise triggered", 32'(triggered), 32'd1);
        check("rise not forced", 32'(forced), 32'd0);
        check("rise armed low", 32'(armed), 32'd0);
        @(negedge clk);
        check("trigger one cycle", 32'(trigger), 32'd0);
        check("triggered held", 32'(triggered), 32'd1);
        pulse_done();
        check("done busy", 32'(busy), 32'd0);
        check("done triggered", 32'(triggered), 32'd0);
        check_drained("rise pending");

        // Falling trigger with no pre-fill.
        config_trig(8'h80, 1'b0, 9'd0, 1'b0);
        pulse_start();
        check("pos0 fill", 32'(armed), 32'd0);
        @(negedge clk);
        check("pos0 armed", 32'(armed), 32'd1);
        send(8'h90, 0, 0);
        send(8'hA0, 0, 0);
        send(8'h70, 1, 0);
        check("fall triggered", 32'(triggered), 32'd1);
        pulse_done();
        check("fall done busy", 32'(busy), 32'd0);
        check_drained("fall pending");

        // Autoroll timeout; autoroll input dropped after start must not matter.
        config_trig(8'h80, 1'b1, 9'd2, 1'b1);
        pulse_start();
        autoroll = 1'b0;
        send(8'h00, 0, 0);
        send(8'h00, 0, 0);
        check("auto armed", 32'(armed), 32'd1);
        for (int i = 0; i < 4095; i++) send(8'h00, 0, 0);
        check("auto still armed", 32'(armed), 32'd1);
        send(8'h00, 1, 1);
        check("auto forced", 32'(forced), 32'd1);
        check("auto triggered", 32'(triggered), 32'd1);
        pulse_done();
        check("auto forced cleared", 32'(forced), 32'd0);
        check_drained("auto pending");

        // Crossing during fill is ignored; first armed crossing triggers.
        config_trig(8'h80, 1'b1, 9'd3, 1'b0);
        pulse_start();
        send(8'h00, 0, 0);
        send(8'hFF, 0, 0);
        send(8'hFF, 0, 0);
        check("fill edge ignored armed", 32'(armed), 32'd1);
        send(8'h10, 0, 0);
        send(8'h90, 1, 0);
        pulse_done();
        check_drained("fill-edge pending");

        // Stop coinciding with an armed edge wins.
        config_trig(8'h80, 1'b1, 9'd0, 1'b0);
        pulse_start();
        @(negedge clk);
        send(8'h10, 0, 0);
        stop = 1'b1;
        send(8'h90, 0, 0);
        stop = 1'b0;
        check("stop busy", 32'(busy), 32'd0);
        check("stop armed", 32'(armed), 32'd0);
        check("stop trigger", 32'(trigger), 32'd0);

        // Reset while in TRIGD clears every output.
        pulse_start();
        @(negedge clk);
        send(8'h10, 0, 0);
        send(8'h90, 1, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst triggered", 32'(triggered), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst armed", 32'(armed), 32'd0);
        check("rst trigger", 32'(trigger), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post rst idle", 32'(busy), 32'd0);
        check_drained("rst pending");

        // Zero level: no rising and no falling crossing is possible.
        config_trig(8'h00, 1'b1, 9'd0, 1'b0);
        pulse_start();
        @(negedge clk);
        send(8'h00, 0, 0);
        send(8'hFF, 0, 0);
        send(8'h00, 0, 0);
        send(8'hFF, 0, 0);
        check("lvl0 rise armed", 32'(armed), 32'd1);
        pulse_stop();
        config_trig(8'h00, 1'b0, 9'd0, 1'b0);
        pulse_start();
        @(negedge clk);
        send(8'hFF, 0, 0);
        send(8'h00, 0, 0);
        check("lvl0 fall armed", 32'(armed), 32'd1);
        pulse_stop();
        check("lvl0 stopped", 32'(busy), 32'd0);

        // Restart while armed is ignored; original level still applies.
        config_trig(8'h80, 1'b1, 9'd0, 1'b0);
        pulse_start();
        @(negedge clk);
        trig_lvl = 8'h20;
        pulse_start();
        check("restart armed", 32'(armed), 32'd1);
        send(8'h10, 0, 0);
        send(8'h30, 0, 0);
        check("old lvl armed", 32'(armed), 32'd1);
        send(8'h90, 1, 0);
        check("old lvl triggered", 32'(triggered), 32'd1);
        pulse_done();
        check_drained("final pending");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trigger_logic.md
TRIGGER_LOGIC -- requirements
Module: trigger_logic

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 smpl_en  in  1  one-cycle strobe marking a valid decimated sample on ch_data.
REQ-004 ch_data  in  8  unsigned channel sample.
REQ-005 trig_lvl  in  8  unsigned trigger threshold, latched on start.
REQ-006 trig_edge  in  1  edge select (1=rising, 0=falling), latched on start.
REQ-007 trig_pos  in  9  pre-trigger sample count, latched on start.
REQ-008 autoroll  in  1  enables forced trigger on timeout, latched on start.
REQ-009 start  in  1  one-cycle pulse beginning an acquisition.
REQ-010 stop  in  1  one-cycle abort pulse.
REQ-011 capture_done  in  1  one-cycle pulse from capture control ending post-trigger fill.
REQ-012 armed  out  1  high while in ARMED.
REQ-013 trigger  out  1  one-cycle pulse on trigger event (edge or forced).
REQ-014 triggered  out  1  high while in TRIGD.
REQ-015 forced  out  1  high in TRIGD when the trigger came from timeout.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states IDLE, FILL, ARMED, TRIGD; all outputs registered.
REQ-018 IDLE: on start, latch trig_lvl/trig_edge/trig_pos/autoroll, clear pre_cnt, clear prev_valid, go FILL.
REQ-019 FILL: pre_cnt (9-bit) increments on each smpl_en; go ARMED in the cycle pre_cnt+1 == latched trig_pos; if trig_pos==0, go ARMED the cycle after entering FILL.
REQ-020 prev sample register loads ch_data on every smpl_en in FILL and ARMED; prev_valid sets on first such load.
REQ-021 Rising edge: prev_valid & prev < lvl & ch_data >= lvl & smpl_en; falling: prev_valid & prev >= lvl & ch_data < lvl & smpl_en.
REQ-022 Edges in FILL are ignored; only ARMED acts on them.
REQ-023 ARMED: on edge, assert trigger next cycle for exactly one cycle, forced=0, go TRIGD.
REQ-024 ARMED with latched autoroll=1: 12-bit to_cnt clears on ARMED entry, increments per smpl_en; on smpl_en when to_cnt==4095 with no edge, trigger pulses, forced=1, go TRIGD.
REQ-025 Edge and timeout in same cycle: edge wins, forced=0.
REQ-026 TRIGD: hold triggered (and forced if set) until capture_done, then go IDLE, clearing forced.
REQ-027 stop in any state returns to IDLE next cycle; stop has priority over start, edge, timeout, capture_done.
REQ-028 start outside IDLE is ignored; capture_done outside TRIGD is ignored.
REQ-029 Input changes to trig_lvl/trig_edge/trig_pos/autoroll after start have no effect until next start.
REQ-030 Level compare is unsigned 8-bit; lvl=0 never yields rising edge; lvl=0 never yields falling edge.

Reset
REQ-031 rst_n low forces IDLE; armed, trigger, triggered, forced, busy = 0; pre_cnt, to_cnt, prev, latched config = 0; prev_valid = 0.
REQ-032 Reset mid-acquisition aborts immediately with no trigger pulse emitted; operation resumes only on a new start.

Structure
REQ-033 Shared package capture_pkg holds the trigger state enum (IDLE, FILL, ARMED, TRIGD) and constant AUTO_TO = 4095.
REQ-034 One sub-module trig_edge_det: prev register, prev_valid, compare, edge-select; outputs a combinational edge flag to the FSM.

Verification
REQ-035 trig_pos=4, lvl=0x80, rising: start, samples 0x10,0x20,0x30,0x40 -> armed after 4th sample; then 0x70,0x90 -> one trigger pulse on the cycle after 0x90, triggered=1, forced=0.
REQ-036 Falling, lvl=0x80, trig_pos=0: samples 0x90,0xA0,0x70 -> trigger after 0x70; capture_done -> IDLE, busy=0.
REQ-037 autoroll=1, constant 0x00 samples, trig_pos=2 -> 4096 samples after armed, trigger pulse with forced=1.
REQ-038 Rising crossing occurs during FILL (trig_pos=3, samples 0x00,0xFF,0xFF) -> no trigger; first qualified crossing after armed triggers.
REQ-039 stop asserted together with an ARMED edge -> no trigger pulse, IDLE next cycle; rst_n low in TRIGD -> all outputs 0.
REQ-040 start pulsed while ARMED with new trig_lvl -> ignored; trigger still uses the originally latched level.
